// File: rtl/tag_store_pkg.sv
// Shared constants and types for the tagged-store controller.
package tag_store_pkg;

    localparam int N_ENTRIES_DEF = 16;
    localparam int IDX_W_DEF     = 4;
    localparam int DATA_W_DEF    = 3;

    // Tag encoding: L entries may be written by either side, H only by high.
    localparam logic TAG_L = 1'b0;
    localparam logic TAG_H = 1'b1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // Round-robin pointer: which side wins when lo and hi collide.
    typedef enum logic {
        RR_LO = 1'b0,
        RR_HI = 1'b1
    } rr_t;

endpackage

// File: rtl/tag_store_arb.sv
// Request arbiter: fixed priority flush > release > lo/hi, with a
// registered 2-way round-robin pointer between the lo and hi requesters.
module tag_store_arb
    import tag_store_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic idle_i,
    input  logic flush_req_i,
    input  logic rel_valid_i,
    input  logic lo_valid_i,
    input  logic hi_valid_i,
    output logic flush_ready_o,
    output logic rel_ready_o,
    output logic lo_ready_o,
    output logic hi_ready_o,
    output logic flush_acc_o,
    output logic rel_acc_o,
    output logic lo_acc_o,
    output logic hi_acc_o
);

    rr_t rr_q;

    // Ready/accept decode; readies are offered only in IDLE and only one
    // requester can see valid & ready in a given cycle.
    always_comb begin
        flush_ready_o = idle_i;
        rel_ready_o   = idle_i & ~flush_req_i;
        lo_ready_o    = idle_i & ~flush_req_i & ~rel_valid_i &
                        (~hi_valid_i | (rr_q == RR_LO));
        hi_ready_o    = idle_i & ~flush_req_i & ~rel_valid_i &
                        (~lo_valid_i | (rr_q == RR_HI));
        flush_acc_o   = flush_req_i & flush_ready_o;
        rel_acc_o     = rel_valid_i & rel_ready_o;
        lo_acc_o      = lo_valid_i & lo_ready_o;
        hi_acc_o      = hi_valid_i & hi_ready_o;
    end

    // Round-robin pointer: after a lo or hi grant, favour the other side.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q <= RR_LO;
        end else if (lo_acc_o) begin
            rr_q <= RR_HI;
        end else if (hi_acc_o) begin
            rr_q <= RR_LO;
        end else begin
            rr_q <= rr_q;
        end
    end

endmodule

// File: rtl/tag_store_ctrl.sv
// Tagged 16-entry store controller: owns the tag vector, arbitrates lo/hi
// writes, blocks lo writes onto H entries, and sequences release and flush.
module tag_store_ctrl
    import tag_store_pkg::*;
#(
    parameter int N_ENTRIES = N_ENTRIES_DEF,
    parameter int IDX_W     = IDX_W_DEF,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 lo_valid,
    input  logic [IDX_W-1:0]     lo_idx,
    input  logic [DATA_W-1:0]    lo_data,
    output logic                 lo_ready,
    output logic                 lo_err,
    input  logic                 hi_valid,
    input  logic [IDX_W-1:0]     hi_idx,
    input  logic [DATA_W-1:0]    hi_data,
    output logic                 hi_ready,
    input  logic                 rel_valid,
    input  logic [IDX_W-1:0]     rel_idx,
    output logic                 rel_ready,
    input  logic                 flush_req,
    output logic                 flush_ready,
    output logic                 flush_done,
    output logic                 wr_en,
    output logic [IDX_W-1:0]     wr_idx,
    output logic [DATA_W-1:0]    wr_data,
    output logic [N_ENTRIES-1:0] tags
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);

    state_t                state_q;
    logic [IDX_W-1:0]      cnt_q;
    logic [N_ENTRIES-1:0]  tags_q;
    logic                  wr_en_q;
    logic [IDX_W-1:0]      wr_idx_q;
    logic [DATA_W-1:0]     wr_data_q;
    logic                  lo_err_q;
    logic                  flush_done_q;

    logic flush_acc_s;
    logic rel_acc_s;
    logic lo_acc_s;
    logic hi_acc_s;

    tag_store_arb u_arb (
        .clk           (clk),
        .rst_n         (rst_n),
        .idle_i        (state_q == ST_IDLE),
        .flush_req_i   (flush_req),
        .rel_valid_i   (rel_valid),
        .lo_valid_i    (lo_valid),
        .hi_valid_i    (hi_valid),
        .flush_ready_o (flush_ready),
        .rel_ready_o   (rel_ready),
        .lo_ready_o    (lo_ready),
        .hi_ready_o    (hi_ready),
        .flush_acc_o   (flush_acc_s),
        .rel_acc_o     (rel_acc_s),
        .lo_acc_o      (lo_acc_s),
        .hi_acc_o      (hi_acc_s)
    );

    // FSM, tag vector and registered write port; pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {IDX_W{1'b0}};
            tags_q       <= {N_ENTRIES{1'b0}};
            wr_en_q      <= 1'b0;
            wr_idx_q     <= {IDX_W{1'b0}};
            wr_data_q    <= {DATA_W{1'b0}};
            lo_err_q     <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            wr_en_q      <= 1'b0;
            lo_err_q     <= 1'b0;
            flush_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (flush_acc_s) begin
                        state_q <= ST_FLUSH;
                        cnt_q   <= {IDX_W{1'b0}};
                    end else if (rel_acc_s) begin
                        tags_q[rel_idx] <= TAG_L;
                        wr_en_q         <= 1'b1;
                        wr_idx_q        <= rel_idx;
                        wr_data_q       <= {DATA_W{1'b0}};
                    end else if (lo_acc_s) begin
                        // Lo writes onto H entries are dropped and flagged.
                        if (tags_q[lo_idx] == TAG_L) begin
                            wr_en_q   <= 1'b1;
                            wr_idx_q  <= lo_idx;
                            wr_data_q <= lo_data;
                        end else begin
                            lo_err_q <= 1'b1;
                        end
                    end else if (hi_acc_s) begin
                        tags_q[hi_idx] <= TAG_H;
                        wr_en_q        <= 1'b1;
                        wr_idx_q       <= hi_idx;
                        wr_data_q      <= hi_data;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    tags_q[cnt_q] <= TAG_L;
                    wr_en_q       <= 1'b1;
                    wr_idx_q      <= cnt_q;
                    wr_data_q     <= {DATA_W{1'b0}};
                    cnt_q         <= cnt_q + IDX_W'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_q      <= ST_IDLE;
                        flush_done_q <= 1'b1;
                    end else begin
                        state_q <= ST_FLUSH;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_idx     = wr_idx_q;
    assign wr_data    = wr_data_q;
    assign lo_err     = lo_err_q;
    assign flush_done = flush_done_q;
    assign tags       = tags_q;

endmodule

// File: tb/tb_tag_store_ctrl.sv
// Directed bench for tag_store_ctrl with a cycle-level reference model and a
// scoreboard queue of expected write-port results.
module tb_tag_store_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lo_valid, hi_valid, rel_valid, flush_req;
    logic [3:0]  lo_idx, hi_idx, rel_idx;
    logic [2:0]  lo_data, hi_data;
    logic        lo_ready, lo_err, hi_ready, rel_ready, flush_ready, flush_done;
    logic        wr_en;
    logic [3:0]  wr_idx;
    logic [2:0]  wr_data;
    logic [15:0] tags;

    tag_store_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .lo_valid(lo_valid), .lo_idx(lo_idx), .lo_data(lo_data),
        .lo_ready(lo_ready), .lo_err(lo_err),
        .hi_valid(hi_valid), .hi_idx(hi_idx), .hi_data(hi_data),
        .hi_ready(hi_ready),
        .rel_valid(rel_valid), .rel_idx(rel_idx), .rel_ready(rel_ready),
        .flush_req(flush_req), .flush_ready(flush_ready), .flush_done(flush_done),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .tags(tags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr_en;
        logic [3:0]  idx;
        logic [2:0]  data;
        logic        lo_err;
        logic        fd;
        logic [15:0] tags;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state
    logic        m_flush;
    logic        m_rr_hi;
    int          m_cnt;
    logic [15:0] m_tags;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("wr_en", {31'd0, wr_en}, {31'd0, e.wr_en});
            if (e.wr_en) begin
                chk("wr_idx", {28'd0, wr_idx}, {28'd0, e.idx});
                chk("wr_data", {29'd0, wr_data}, {29'd0, e.data});
            end
            chk("lo_err", {31'd0, lo_err}, {31'd0, e.lo_err});
            chk("flush_done", {31'd0, flush_done}, {31'd0, e.fd});
            chk("tags", {16'd0, tags}, {16'd0, e.tags});
        end
    endtask

    task automatic step(input logic fr, input logic rv, input logic [3:0] ri,
                        input logic lv, input logic [3:0] li, input logic [2:0] ld,
                        input logic hv, input logic [3:0] hix, input logic [2:0] hd);
        exp_t e;
        logic idle, lo_win;
        @(negedge clk);
        pop_check();
        flush_req = fr; rel_valid = rv; rel_idx = ri;
        lo_valid = lv; lo_idx = li; lo_data = ld;
        hi_valid = hv; hi_idx = hix; hi_data = hd;
        #1;
        idle   = ~m_flush;
        lo_win = lv & (~hv | ~m_rr_hi);
        chk("flush_ready", {31'd0, flush_ready}, {31'd0, idle});
        chk("rel_ready", {31'd0, rel_ready}, {31'd0, idle & ~fr});
        chk("lo_ready", {31'd0, lo_ready}, {31'd0, idle & ~fr & ~rv & (~hv | ~m_rr_hi)});
        chk("hi_ready", {31'd0, hi_ready}, {31'd0, idle & ~fr & ~rv & (~lv | m_rr_hi)});
        e.wr_en = 1'b0; e.idx = 4'd0; e.data = 3'd0; e.lo_err = 1'b0; e.fd = 1'b0;
        if (m_flush) begin
            m_tags[m_cnt] = 1'b0;
            e.wr_en = 1'b1; e.idx = 4'(m_cnt);
            if (m_cnt == 15) begin
                m_flush = 1'b0; e.fd = 1'b1; m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end else if (fr) begin
            m_flush = 1'b1; m_cnt = 0;
        end else if (rv) begin
            m_tags[ri] = 1'b0;
            e.wr_en = 1'b1; e.idx = ri;
        end else if (lo_win) begin
            m_rr_hi = 1'b1;
            if (m_tags[li]) e.lo_err = 1'b1;
            else begin e.wr_en = 1'b1; e.idx = li; e.data = ld; end
        end else if (hv) begin
            m_rr_hi = 1'b0;
            m_tags[hix] = 1'b1;
            e.wr_en = 1'b1; e.idx = hix; e.data = hd;
        end
        e.tags = m_tags;
        q.push_back(e);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 4'd0, 0, 4'd0, 3'd0, 0, 4'd0, 3'd0);
    endtask

    task automatic hi_wr(input logic [3:0] i, input logic [2:0] d);
        step(0, 0, 4'd0, 0, 4'd0, 3'd0, 1, i, d);
    endtask

    task automatic lo_wr(input logic [3:0] i, input logic [2:0] d);
        step(0, 0, 4'd0, 1, i, d, 0, 4'd0, 3'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        pop_check();
        rst_n = 1'b0;
        flush_req = 0; rel_valid = 0; lo_valid = 0; hi_valid = 0;
        @(negedge clk);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_wr_idx", {28'd0, wr_idx}, 32'd0);
        chk("rst_tags", {16'd0, tags}, 32'd0);
        chk("rst_flush_done", {31'd0, flush_done}, 32'd0);
        chk("rst_lo_err", {31'd0, lo_err}, 32'd0);
        rst_n = 1'b1;
        q.delete();
        m_flush = 1'b0; m_rr_hi = 1'b0; m_cnt = 0; m_tags = 16'h0000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        flush_req = 0; rel_valid = 0; lo_valid = 0; hi_valid = 0;
        lo_idx = 0; hi_idx = 0; rel_idx = 0; lo_data = 0; hi_data = 0;
        do_reset();
        idle_n(3);

        // H write then blocked lo write to the same entry
        hi_wr(4'd5, 3'b101);
        lo_wr(4'd5, 3'd2);
        idle_n(1);
        chk("tags_after_hi5", {16'd0, tags}, 32'h0020);

        // Steer rr back to LO, then collide lo/hi for four cycles
        hi_wr(4'd12, 3'd1);
        for (int i = 0; i < 4; i++) step(0, 0, 4'd0, 1, 4'd1, 3'd1, 1, 4'd2, 3'd2);
        idle_n(1);

        // Release beats lo; released entry is writable by lo again
        hi_wr(4'd7, 3'd6);
        step(0, 1, 4'd7, 1, 4'd3, 3'd3, 0, 4'd0, 3'd0);
        lo_wr(4'd7, 3'd4);
        idle_n(1);

        // Full flush
        hi_wr(4'd0, 3'd7);
        hi_wr(4'd9, 3'd7);
        hi_wr(4'd15, 3'd7);
        step(1, 0, 4'd0, 0, 4'd0, 3'd0, 0, 4'd0, 3'd0);
        for (int i = 0; i < 16; i++) step(0, 0, 4'd0, 1, 4'd3, 3'd1, 1, 4'd4, 3'd2);
        idle_n(2);
        chk("tags_after_flush", {16'd0, tags}, 32'h0000);

        // Reset during flush cycle k=6 aborts without flush_done
        hi_wr(4'd3, 3'd5);
        step(1, 0, 4'd0, 0, 4'd0, 3'd0, 0, 4'd0, 3'd0);
        idle_n(6);
        do_reset();
        idle_n(20);
        @(negedge clk);
        pop_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
